// File: rtl/fpro_arb_pkg.sv
// fpro_arb_pkg: shared types and constants for the FPRO two-master bus arbiter.
//   - arb_state_e : arbiter FSM states (IDLE, XFER, ACK)
//   - mid_t       : one-bit master identifier (0 = MCS bridge, 1 = secondary master)
//   - FPRO_ADDR_W / FPRO_DATA_W : default bus widths
package fpro_arb_pkg;

  localparam int FPRO_ADDR_W = 21;
  localparam int FPRO_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    ACK  = 2'd2
  } arb_state_e;

  typedef logic mid_t;

  localparam mid_t MID_M0 = 1'b0;
  localparam mid_t MID_M1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick.
// Ports:
//   req_i       [1:0] request from master 0 (bit 0) and master 1 (bit 1)
//   last_i            master granted most recently; loses a tie
//   mask_m1_i         ignore master 1's request this cycle
//   gnt_valid_o       at least one unmasked request is present
//   gnt_id_o          chosen master (meaningful only when gnt_valid_o = 1)
module rr_arb2
  import fpro_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  mid_t       last_i,
  input  logic       mask_m1_i,
  output logic       gnt_valid_o,
  output mid_t       gnt_id_o
);

  logic [1:0] eff_req;

  assign eff_req     = {req_i[1] & ~mask_m1_i, req_i[0]};
  assign gnt_valid_o = |eff_req;
  // On a tie the master that did not win last time goes next; otherwise the
  // single requester wins (bit 1 set means it is master 1).
  assign gnt_id_o    = (&eff_req) ? ~last_i : eff_req[1];

endmodule

// File: rtl/fpro_bus_arbiter.sv
// fpro_bus_arbiter: serialises single-word transactions from two masters
// (m0 = MCS bridge, m1 = secondary master) onto the FPRO MMIO bus with
// round-robin arbitration. Each transaction takes IDLE -> XFER -> ACK.
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   mN_req/_wr/_addr/_wr_data      master N request (held until mN_ack)
//   mN_ack, mN_rd_data             one-cycle completion pulse, read return
//   m0_lock                        master 0 bus lock (FPRO_ARB_LOCK_EN only)
//   fp_mmio_cs/_wr/_rd/_addr/_wr_data  FPRO bus outputs, all registered
//   fp_rd_data                     FPRO read data, sampled at end of XFER
// Build option: define FPRO_ARB_LOCK_EN to add the m0_lock port and feature.
module fpro_bus_arbiter
  import fpro_arb_pkg::*;
#(
  parameter int ADDR_W = FPRO_ADDR_W,
  parameter int DATA_W = FPRO_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rd_data,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rd_data,
`ifdef FPRO_ARB_LOCK_EN
  input  logic              m0_lock,
`endif
  output logic              fp_mmio_cs,
  output logic              fp_wr,
  output logic              fp_rd,
  output logic [ADDR_W-1:0] fp_addr,
  output logic [DATA_W-1:0] fp_wr_data,
  input  logic [DATA_W-1:0] fp_rd_data
);

  arb_state_e        state_q;
  mid_t              last_q;
  mid_t              gnt_q;
  logic              fp_cs_q, fp_wr_q, fp_rd_q;
  logic [ADDR_W-1:0] fp_addr_q;
  logic [DATA_W-1:0] fp_wr_data_q;
  logic              m0_ack_q, m1_ack_q;
  logic [DATA_W-1:0] m0_rd_data_q, m1_rd_data_q;

  logic              gnt_valid;
  mid_t              gnt_id;
  logic              mask_m1;
  logic              sel_wr_d;
  logic [ADDR_W-1:0] sel_addr_d;
  logic [DATA_W-1:0] sel_wr_data_d;

`ifdef FPRO_ARB_LOCK_EN
  // Lock only takes hold once master 0 owns the bus (it was granted last);
  // while masked only m0 can win, so last_q stays M0 and the mask persists
  // for as long as the lock is held. Dropping it leaves last_q = M0, which
  // hands the next tie to m1.
  assign mask_m1 = m0_lock && (last_q == MID_M0);
`else
  assign mask_m1 = 1'b0;
`endif

  rr_arb2 u_rr_arb2 (
    .req_i       ({m1_req, m0_req}),
    .last_i      (last_q),
    .mask_m1_i   (mask_m1),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  // Request fields of whichever master the picker selected.
  always_comb begin
    sel_wr_d      = m0_wr;
    sel_addr_d    = m0_addr;
    sel_wr_data_d = m0_wr_data;
    if (gnt_id == MID_M1) begin
      sel_wr_d      = m1_wr;
      sel_addr_d    = m1_addr;
      sel_wr_data_d = m1_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_q       <= MID_M1;
      gnt_q        <= MID_M0;
      fp_cs_q      <= 1'b0;
      fp_wr_q      <= 1'b0;
      fp_rd_q      <= 1'b0;
      fp_addr_q    <= '0;
      fp_wr_data_q <= '0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_rd_data_q <= '0;
      m1_rd_data_q <= '0;
    end else begin
      // Acks are single-cycle pulses; only the XFER branch raises one.
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            gnt_q        <= gnt_id;
            last_q       <= gnt_id;
            fp_addr_q    <= sel_addr_d;
            fp_wr_data_q <= sel_wr_data_d;
            fp_cs_q      <= 1'b1;
            fp_wr_q      <= sel_wr_d;
            fp_rd_q      <= ~sel_wr_d;
            state_q      <= XFER;
          end
        end
        XFER: begin
          fp_cs_q <= 1'b0;
          fp_wr_q <= 1'b0;
          fp_rd_q <= 1'b0;
          if (fp_rd_q) begin
            if (gnt_q == MID_M1) m1_rd_data_q <= fp_rd_data;
            else                 m0_rd_data_q <= fp_rd_data;
          end
          if (gnt_q == MID_M1) m1_ack_q <= 1'b1;
          else                 m0_ack_q <= 1'b1;
          state_q <= ACK;
        end
        ACK: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign fp_mmio_cs = fp_cs_q;
  assign fp_wr      = fp_wr_q;
  assign fp_rd      = fp_rd_q;
  assign fp_addr    = fp_addr_q;
  assign fp_wr_data = fp_wr_data_q;
  assign m0_ack     = m0_ack_q;
  assign m1_ack     = m1_ack_q;
  assign m0_rd_data = m0_rd_data_q;
  assign m1_rd_data = m1_rd_data_q;

endmodule

// File: tb/tb_fpro_bus_arbiter.sv
// tb_fpro_bus_arbiter: directed plus randomized bench for fpro_bus_arbiter.
// A transaction-level reference model predicts every bus output each cycle
// from the arbitration rules; acks seen from the DUT are logged for the
// grant-order checks. Define FPRO_ARB_LOCK_EN to exercise the lock feature.
module tb_fpro_bus_arbiter;

  localparam int AW = 21;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req;
  logic [1:0]    wr;
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic          m0_ack, m1_ack;
  logic [DW-1:0] m0_rd_data, m1_rd_data;
  logic          fp_mmio_cs, fp_wr, fp_rd;
  logic [AW-1:0] fp_addr;
  logic [DW-1:0] fp_wr_data;
  logic [DW-1:0] fp_rd_data;
`ifdef FPRO_ARB_LOCK_EN
  logic          m0_lock;
`endif

  always #5 clk = ~clk;

  fpro_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .m0_req     (req[0]),
    .m0_wr      (wr[0]),
    .m0_addr    (addr[0]),
    .m0_wr_data (wdata[0]),
    .m0_ack     (m0_ack),
    .m0_rd_data (m0_rd_data),
    .m1_req     (req[1]),
    .m1_wr      (wr[1]),
    .m1_addr    (addr[1]),
    .m1_wr_data (wdata[1]),
    .m1_ack     (m1_ack),
    .m1_rd_data (m1_rd_data),
`ifdef FPRO_ARB_LOCK_EN
    .m0_lock    (m0_lock),
`endif
    .fp_mmio_cs (fp_mmio_cs),
    .fp_wr      (fp_wr),
    .fp_rd      (fp_rd),
    .fp_addr    (fp_addr),
    .fp_wr_data (fp_wr_data),
    .fp_rd_data (fp_rd_data)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: a transaction is "busy" from its grant until the
  // cycle after its ack; age 0 = bus strobe cycle, age 1 = ack cycle.
  bit            busy;
  int            age;
  bit            mlast;
  bit            mgnt;
  bit            mwr;
  bit            e_cs, e_wr, e_rd;
  bit            e_ack [2];
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic [DW-1:0] e_rdd [2];

  // Bench-side master behaviour.
  bit            auto_en  [2];
  bit            rel_pend [2];
  int            pct;
  bit            force_rd;
  logic [DW-1:0] force_val;

  // Acks observed on the DUT outputs.
  int            ack_id  [$];
  int            ack_cyc [$];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit c0, c1, g, masked;
    e_cs = 0; e_wr = 0; e_rd = 0;
    e_ack[0] = 0; e_ack[1] = 0;
    masked = 0;
`ifdef FPRO_ARB_LOCK_EN
    masked = m0_lock && (mlast == 1'b0);
`endif
    if (!rst) begin
      busy = 0; mlast = 1;
      e_addr = '0; e_wdata = '0; e_rdd[0] = '0; e_rdd[1] = '0;
    end else if (!busy) begin
      c0 = req[0];
      c1 = req[1] && !masked;
      if (c0 || c1) begin
        g = (c0 && c1) ? !mlast : c1;
        busy = 1; age = 0; mgnt = g; mlast = g; mwr = wr[g];
        e_addr = addr[g]; e_wdata = wdata[g];
        e_cs = 1; e_wr = mwr; e_rd = !mwr;
      end
    end else if (age == 0) begin
      e_ack[mgnt] = 1;
      if (!mwr) e_rdd[mgnt] = fp_rd_data;
      age = 1;
    end else begin
      busy = 0;
    end
  endtask

  task automatic new_req(int m);
    logic [31:0] r;
    r = $urandom;
    req[m]   = 1'b1;
    wr[m]    = r[31];
    addr[m]  = r[AW-1:0];
    wdata[m] = $urandom;
  endtask

  // One clock: step the model with the inputs the DUT just sampled, compare
  // every output, then update the stimulus for the next edge.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    model_step();
    chk("fp_mmio_cs", 64'(fp_mmio_cs), 64'(e_cs));
    chk("fp_wr",      64'(fp_wr),      64'(e_wr));
    chk("fp_rd",      64'(fp_rd),      64'(e_rd));
    chk("fp_addr",    64'(fp_addr),    64'(e_addr));
    chk("fp_wr_data", 64'(fp_wr_data), 64'(e_wdata));
    chk("m0_ack",     64'(m0_ack),     64'(e_ack[0]));
    chk("m1_ack",     64'(m1_ack),     64'(e_ack[1]));
    chk("m0_rd_data", 64'(m0_rd_data), 64'(e_rdd[0]));
    chk("m1_rd_data", 64'(m1_rd_data), 64'(e_rdd[1]));
    if (m0_ack) begin ack_id.push_back(0); ack_cyc.push_back(cyc); end
    if (m1_ack) begin ack_id.push_back(1); ack_cyc.push_back(cyc); end
    if (m0_ack || m1_ack)
      $display("cyc %0d ack m%0d wr=%0b addr=%0h wdata=%0h rd0=%0h rd1=%0h",
               cyc, m1_ack, mwr, e_addr, e_wdata, m0_rd_data, m1_rd_data);
    for (int m = 0; m < 2; m++) begin
      if (e_ack[m]) begin
        rel_pend[m] = 1;
      end else if (rel_pend[m]) begin
        rel_pend[m] = 0;
        req[m] = 1'b0;
        if (auto_en[m] && $urandom_range(99) < pct) new_req(m);
      end else if (!req[m] && auto_en[m] && $urandom_range(99) < pct) begin
        new_req(m);
      end
    end
    fp_rd_data = force_rd ? force_val : $urandom;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Advance to an IDLE cycle of the model (bounded).
  task automatic to_idle();
    int k;
    k = 0;
    while (busy && k < 10) begin cycle(); k++; end
    chk("idle_reached", 64'(busy), 64'(0));
  endtask

  int n0;

  initial begin
    rst = 1'b0; req = '0; wr = '0;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    fp_rd_data = '0; force_rd = 0; force_val = '0; pct = 0;
    auto_en[0] = 0; auto_en[1] = 0; rel_pend[0] = 0; rel_pend[1] = 0;
    busy = 0; age = 0; mlast = 1; mgnt = 0; mwr = 0;
`ifdef FPRO_ARB_LOCK_EN
    m0_lock = 1'b0;
`endif

    // Reset state.
    run(3);
    chk("rst_cs", 64'(fp_mmio_cs), 64'(0));
    chk("rst_rd0", 64'(m0_rd_data), 64'(0));
    rst = 1'b1;
    run(2);

    // m0 write 0x00010 / 0xDEADBEEF.
    req[0] = 1; wr[0] = 1; addr[0] = 21'h00010; wdata[0] = 32'hDEAD_BEEF;
    cycle();
    chk("w_cs", 64'(fp_mmio_cs), 64'(1));
    chk("w_wr", 64'(fp_wr), 64'(1));
    chk("w_addr", 64'(fp_addr), 64'h10);
    chk("w_data", 64'(fp_wr_data), 64'hDEAD_BEEF);
    cycle();
    chk("w_ack0", 64'(m0_ack), 64'(1));
    chk("w_ack1", 64'(m1_ack), 64'(0));
    run(1);

    // m1 read 0x00020 returning 0x12345678.
    req[1] = 1; wr[1] = 0; addr[1] = 21'h00020; wdata[1] = '0;
    force_rd = 1; force_val = 32'h1234_5678;
    cycle();
    chk("r_rd", 64'(fp_rd), 64'(1));
    chk("r_addr", 64'(fp_addr), 64'h20);
    cycle();
    chk("r_ack1", 64'(m1_ack), 64'(1));
    chk("r_data1", 64'(m1_rd_data), 64'h1234_5678);
    chk("r_data0", 64'(m0_rd_data), 64'(0));
    force_rd = 0;
    run(2);

    // Continuous requests from both masters: strict alternation, 3 cycles apart.
    to_idle();
    n0 = ack_id.size();
    auto_en[0] = 1; auto_en[1] = 1; pct = 100;
    new_req(0); new_req(1);
    run(18);
    auto_en[0] = 0; auto_en[1] = 0;
    run(6);
    chk("rr_count", 64'(ack_id.size() - n0 >= 6), 64'(1));
    for (int i = 0; i < 6; i++) begin
      if (n0 + i < ack_id.size()) begin
        chk("rr_order", 64'(ack_id[n0 + i]), 64'(i % 2));
        if (i > 0) chk("rr_spacing", 64'(ack_cyc[n0 + i] - ack_cyc[n0 + i - 1]), 64'(3));
      end
    end

    // Reset during XFER: no ack, no capture, outputs back to 0.
    req[0] = 1; wr[0] = 0; addr[0] = 21'h1F0F0;
    cycle();
    chk("mx_cs", 64'(fp_mmio_cs), 64'(1));
    rst = 1'b0;
    cycle();
    chk("mx_ack0", 64'(m0_ack), 64'(0));
    chk("mx_cs0", 64'(fp_mmio_cs), 64'(0));
    chk("mx_rd0", 64'(m0_rd_data), 64'(0));
    chk("mx_addr", 64'(fp_addr), 64'(0));
    req[0] = 0; rel_pend[0] = 0; rel_pend[1] = 0;
    rst = 1'b1;
    run(4);

`ifdef FPRO_ARB_LOCK_EN
    // Lock: m0 keeps the bus; on release m1 wins the next grant.
    n0 = ack_id.size();
    m0_lock = 1'b1;
    auto_en[0] = 1; auto_en[1] = 1; pct = 100;
    new_req(0); new_req(1);
    run(12);
    for (int i = 0; i < 3; i++)
      chk("lock_m0", 64'(ack_id[n0 + i]), 64'(0));
    to_idle();
    n0 = ack_id.size();
    m0_lock = 1'b0;
    run(6);
    chk("unlock_m1", 64'(ack_id[n0]), 64'(1));
    auto_en[0] = 0; auto_en[1] = 0;
    run(8);
`endif

    // Randomized traffic with occasional resets.
    auto_en[0] = 1; auto_en[1] = 1; pct = 40;
    for (int i = 0; i < 2000; i++) begin
      cycle();
      rst = ($urandom_range(299) != 0);
`ifdef FPRO_ARB_LOCK_EN
      if ($urandom_range(19) == 0) m0_lock = ~m0_lock;
`endif
    end
    rst = 1'b1;
    auto_en[0] = 0; auto_en[1] = 0;
    run(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpro_bus_arbiter.md
# fpro_bus_arbiter

Two-master arbiter for the FPRO MMIO bus. It sits between the MCS bridge (master 0) and a secondary bus master such as a DMA or debug engine (master 1), and the MMIO subsystem. It serialises single-word read/write transactions from both masters onto the one FPRO bus. Arbitration is round-robin, and each master gets a registered acknowledge and read-data return.

## Interface
Parameters:
- ADDR_W, 21, FPRO register address width
- DATA_W, 32, FPRO data width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- m0_req  in  1  master 0 transaction request, held until m0_ack
- m0_wr  in  1  master 0: 1 = write, 0 = read
- m0_addr  in  ADDR_W  master 0 address
- m0_wr_data  in  DATA_W  master 0 write data
- m0_ack  out  1  one-cycle completion pulse to master 0
- m0_rd_data  out  DATA_W  master 0 read return, valid with m0_ack
- m1_req, m1_wr, m1_addr, m1_wr_data, m1_ack, m1_rd_data: same as master 0, for master 1
- m0_lock  in  1  master 0 bus lock; exists only with FPRO_ARB_LOCK_EN
- fp_mmio_cs  out  1  FPRO chip select
- fp_wr  out  1  FPRO write strobe
- fp_rd  out  1  FPRO read strobe
- fp_addr  out  ADDR_W  FPRO address
- fp_wr_data  out  DATA_W  FPRO write data
- fp_rd_data  in  DATA_W  FPRO read data, combinational from the slot in the same cycle

## Operation
- FSM states: IDLE, XFER, ACK.
- IDLE: sample m0_req and m1_req.
  - Neither high: stay in IDLE.
  - One high: grant that master.
  - Both high: grant the master that is not `last`.
  - On grant: register the granted master's wr, addr and wr_data into the bus registers, update `last`, go to XFER.
- XFER: drive fp_mmio_cs = 1 and fp_wr = wr or fp_rd = ~wr, for exactly one cycle.
  - Read: capture fp_rd_data into the granted master's rd_data register at the end of the cycle.
  - Write: the rd_data registers are unchanged.
  - Go to ACK.
- ACK: pulse the granted master's ack for one cycle; all fp_* strobes are 0. Go to IDLE.
- mN_rd_data holds its last captured value until that master's next read completes.
- Masters must hold req, wr, addr and wr_data stable from req assertion through the ack cycle. The arbiter samples these only in IDLE.
- Req still high in the ACK cycle (or after) is a new request and is arbitrated fresh in the next IDLE cycle. There is no early drop after grant: a transaction, once granted, always completes.
- Fairness: under continuous requests from both masters, grants alternate m0, m1, m0, ...
- Reset (rst = 0 on a clock edge):
  - State goes to IDLE and `last` = 1, so m0 wins the first tie.
  - fp_mmio_cs, fp_wr, fp_rd, m0_ack and m1_ack = 0.
  - fp_addr, fp_wr_data, m0_rd_data and m1_rd_data = 0.
  - Any in-flight transaction is dropped with no ack. This holds also when reset is asserted in XFER (no read data is captured).
- Only the granted master's ack is ever asserted; both acks are never high together.

## Timing
- Request seen in IDLE at cycle t: bus strobe at t+1, ack and read data at t+2.
- Throughput: one transaction per 3 cycles; the next grant is at the earliest at t+3.
- Back-to-back requests from different masters: the second master is strobed at t+4.
- All outputs are registered; there is no combinational path from mN_* inputs or fp_rd_data to any output.

## Configuration
- FPRO_ARB_LOCK_EN defined:
  - The m0_lock port exists.
  - If m0_lock is high in the IDLE cycle after an m0 transaction, m1_req is masked and only m0 can be granted. Arbitration stays in IDLE until m0_req rises.
  - The mask holds while m0_lock stays high.
  - Dropping m0_lock restores round-robin from that IDLE cycle, with `last` = 0 so m1 wins the next tie.
- FPRO_ARB_LOCK_EN undefined: no m0_lock port; pure round-robin as described.

## Structure
- Package fpro_arb_pkg:
  - FSM state enum: IDLE, XFER, ACK.
  - Default ADDR_W/DATA_W constants.
  - Master-id typedef (1 bit).
- One sub-module, rr_arb2: combinational two-way round-robin pick. Inputs: req[1:0], last, mask_m1. Outputs: grant valid and grant id. It is instantiated once; the top level holds the FSM and all registers.

## Test plan
- Reset: after reset, all fp_* outputs, both acks and both rd_data = 0, state IDLE. Assert reset mid-XFER → no ack, outputs return to 0.
- m0 write addr 0x00010, data 0xDEAD_BEEF → fp_mmio_cs = fp_wr = 1 for one cycle with that address and data at t+1; m0_ack at t+2; m1_ack stays 0.
- m1 read addr 0x00020 with fp_rd_data = 0x1234_5678 in the XFER cycle → m1_rd_data = 0x1234_5678 with m1_ack at t+2; m0_rd_data unchanged.
- Both masters request continuously for 6 transactions → grant order m0, m1, m0, m1, m0, m1; one strobe every 3 cycles.
- With FPRO_ARB_LOCK_EN: m0_lock high and both requesting → 3 consecutive m0 transactions. Lower lock → the next grant goes to m1.
